tdm_demux_8ch: RTL and testbench
================================

Name: tdm_demux_8ch

Overview:
- Receive end of the 8-channel select/multiplex path.
- Takes a time-division-multiplexed stream of W-bit samples (one sample per slot, 8 slots per frame; slot 0 is marked by frame_sync) and distributes each sample to its channel.
- Samples are collected in a shadow buffer and presented on the parallel outputs in a single cycle at frame end, so all 8 channel outputs always belong to the same frame.
- Sits after the serial link, feeding per-channel logic.

Parameters:
- W, 1, width in bits of one channel sample (W >= 1).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- din  input  W  sample for the current slot.
- din_valid  input  1  din carries a sample this cycle.
- frame_sync  input  1  qualified by din_valid; marks the sample as slot 0.
- y  output  8*W  channel outputs; channel k at bits [k*W +: W]; registered.
- sel  output  3  slot index expected for the next valid sample; registered.
- frame_done  output  1  one-cycle pulse, same cycle y updates.
- sync_err  output  1  one-cycle pulse on framing error.
- locked  output  1  1 while in RUN.

Behaviour:
- Reset (async, rst=1):
  - y=0, sel=0, frame_done=0, sync_err=0, locked=0.
  - Shadow buffer cleared; state=IDLE.
  - Takes effect immediately, mid-frame included; the partial frame is discarded.
- States: IDLE (hunting for sync), RUN (locked).
- din_valid=0: no state change, no capture, sel and y hold. Pulses are 0.
- IDLE:
  - valid sample with frame_sync=0: dropped, no pulse.
  - valid sample with frame_sync=1: shadow[0]<=din, sel<=1, go RUN, locked<=1.
- RUN, valid sample, sel=s:
  - s=0, frame_sync=1: shadow[0]<=din, sel<=1.
  - s=0, frame_sync=0 (missing sync):
    - sample dropped, sync_err pulse, go IDLE, locked<=0, sel<=0.
    - Shadow is cleared; y holds its last completed frame.
  - s in 1..6, frame_sync=0: shadow[s]<=din, sel<=s+1.
  - s in 1..7, frame_sync=1 (early sync):
    - sync_err pulse; partial frame discarded (shadow cleared).
    - The sample is taken as a new slot 0: shadow[0]<=din, sel<=1. Stay in RUN.
  - s=7, frame_sync=0: frame completes.
    - y[k] <= shadow[k] for k=0..6; y[7] <= din.
    - frame_done pulse, sel wraps to 0, shadow cleared.
- Latency and output rules:
  - y changes only on frame completion or reset.
  - Latency from the slot-7 sample to y/frame_done is 1 clock (registered).
- Simultaneous events:
  - sync_err and frame_done are never asserted in the same cycle.
  - A sync error on slot 7 takes priority over completion; no y update.
- sel is 3 bits; it wraps from 7 to 0 only on completion.

Test Plan:
- W=1; rst pulse mid-frame at slot 4 -> y=0, sel=0, locked=0 immediately, before the next clk edge; the next frame needs a new sync.
- W=1; sync+din=1, then din=0,1,1,0,0,1,0 (slots 1-7), all valid -> one cycle after slot 7: y=8'b0100_1101 (ch0=bit0), frame_done=1 for one cycle, sel=0.
- W=4; two back-to-back frames with samples 0x0..0x7 then 0x8..0xF, with din_valid=0 gaps inserted -> y=0x76543210 after frame 1, y=0xFEDCBA98 after frame 2; y stable during gaps and mid-frame.
- W=1; locked, frame_sync at slot 3 -> sync_err pulse, sel=1, no frame_done; the following 7 samples complete a frame, and y reflects only post-resync data.
- W=1; locked, slot-0 sample without frame_sync -> sync_err pulse, locked=0, y keeps its previous frame; samples without sync are ignored until the next sync.
- W=1; valid samples in IDLE without sync -> no pulses, sel=0, y unchanged.

Source files
------------

// File: rtl/tdm_demux_8ch.sv
// Receive side of the 8-slot TDM link: collects one frame of W-bit samples in a shadow
// buffer and publishes all eight channels together when slot 7 arrives.
module tdm_demux_8ch #(
    parameter int unsigned W = 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [W-1:0]   din,
    input  logic           din_valid,
    input  logic           frame_sync,
    output logic [8*W-1:0] y,
    output logic [2:0]     sel,
    output logic           frame_done,
    output logic           sync_err,
    output logic           locked
);

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e           state_q, state_d;
    logic [2:0]       sel_q, sel_d;
    // Slots 0..6 only; slot 7 goes straight from din into y on completion.
    logic [7*W-1:0]   shadow_q, shadow_d;
    logic [8*W-1:0]   y_q, y_d;
    logic             frame_done_q, frame_done_d;
    logic             sync_err_q, sync_err_d;

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        shadow_d     = shadow_q;
        y_d          = y_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;

        if (din_valid) begin
            unique case (state_q)
                StIdle: begin
                    if (frame_sync) begin
                        shadow_d           = '0;
                        shadow_d[0 +: W]   = din;
                        sel_d              = 3'd1;
                        state_d            = StRun;
                    end
                end
                StRun: begin
                    if (frame_sync) begin
                        // Sync anywhere but slot 0 restarts the frame on this sample.
                        sync_err_d       = (sel_q != 3'd0);
                        shadow_d         = '0;
                        shadow_d[0 +: W] = din;
                        sel_d            = 3'd1;
                    end else if (sel_q == 3'd0) begin
                        sync_err_d = 1'b1;
                        shadow_d   = '0;
                        sel_d      = 3'd0;
                        state_d    = StIdle;
                    end else if (sel_q == 3'd7) begin
                        y_d          = {din, shadow_q};
                        frame_done_d = 1'b1;
                        shadow_d     = '0;
                        sel_d        = 3'd0;
                    end else begin
                        for (int k = 1; k < 7; k++) begin
                            if (sel_q == 3'(k)) begin
                                shadow_d[k*W +: W] = din;
                            end
                        end
                        sel_d = sel_q + 3'd1;
                    end
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            sel_q        <= 3'd0;
            shadow_q     <= '0;
            y_q          <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            shadow_q     <= shadow_d;
            y_q          <= y_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign y          = y_q;
    assign sel        = sel_q;
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;
    assign locked     = (state_q == StRun);

endmodule

// File: tb/tb_tdm_demux_8ch.sv
// Randomized and directed checks of tdm_demux_8ch at W=1 and W=4 against a queue-based
// frame model.
module tb_tdm_demux_8ch;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  din4;
    logic [0:0]  din1;
    logic        din_valid;
    logic        frame_sync;
    logic [7:0]  y1;
    logic [31:0] y4;
    logic [2:0]  sel1, sel4;
    logic        fd1, fd4, se1, se4, lk1, lk4;

    always #5 clk = ~clk;

    tdm_demux_8ch #(.W(1)) u_dut1 (
        .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid), .frame_sync(frame_sync),
        .y(y1), .sel(sel1), .frame_done(fd1), .sync_err(se1), .locked(lk1)
    );

    tdm_demux_8ch #(.W(4)) u_dut4 (
        .clk(clk), .rst(rst), .din(din4), .din_valid(din_valid), .frame_sync(frame_sync),
        .y(y4), .sel(sel4), .frame_done(fd4), .sync_err(se4), .locked(lk4)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: a frame is just the list of samples gathered since the last sync.
    bit         m_hunt;
    logic [3:0] m_frame[$];
    logic [3:0] m_y[8];
    bit         m_done, m_err;

    function automatic void model_reset();
        m_hunt = 1'b1;
        m_frame.delete();
        for (int k = 0; k < 8; k++) m_y[k] = 4'h0;
        m_done = 1'b0;
        m_err  = 1'b0;
    endfunction

    function automatic void model_step(input bit v, input bit fs, input logic [3:0] d);
        m_done = 1'b0;
        m_err  = 1'b0;
        if (!v) return;
        if (m_hunt) begin
            if (fs) begin
                m_frame.delete();
                m_frame.push_back(d);
                m_hunt = 1'b0;
            end
        end else if (fs) begin
            m_err = (m_frame.size() != 0);
            m_frame.delete();
            m_frame.push_back(d);
        end else if (m_frame.size() == 0) begin
            m_err  = 1'b1;
            m_hunt = 1'b1;
        end else begin
            m_frame.push_back(d);
            if (m_frame.size() == 8) begin
                for (int k = 0; k < 8; k++) m_y[k] = m_frame[k];
                m_frame.delete();
                m_done = 1'b1;
            end
        end
    endfunction

    function automatic int model_sel();
        return m_hunt ? 0 : m_frame.size();
    endfunction

    task automatic compare_all();
        logic [7:0]  e1;
        logic [31:0] e4;
        for (int k = 0; k < 8; k++) begin
            e1[k]         = m_y[k][0];
            e4[k*4 +: 4]  = m_y[k];
        end
        check("y_w1", {24'h0, y1}, {24'h0, e1});
        check("y_w4", y4, e4);
        check("sel_w1", {29'h0, sel1}, 32'(model_sel()));
        check("sel_w4", {29'h0, sel4}, 32'(model_sel()));
        check("frame_done", {30'h0, fd1, fd4}, {30'h0, m_done, m_done});
        check("sync_err", {30'h0, se1, se4}, {30'h0, m_err, m_err});
        check("locked", {30'h0, lk1, lk4}, {30'h0, !m_hunt, !m_hunt});
    endtask

    task automatic cyc(input bit v, input bit fs, input logic [3:0] d);
        din_valid  = v;
        frame_sync = fs;
        din4       = d;
        din1       = d[0];
        @(posedge clk);
        #1;
        model_step(v, fs, d);
        compare_all();
    endtask

    // Reset asserted between edges; outputs must clear before the next edge.
    task automatic mid_reset();
        #2;
        rst = 1'b1;
        #1;
        check("rst_y", {y4[31:8], y4[7:0] | y1}, 32'h0);
        check("rst_sel", {26'h0, sel1, sel4}, 32'h0);
        check("rst_flags", {26'h0, lk1, lk4, fd1, fd4, se1, se4}, 32'h0);
        model_reset();
        #1;
        rst = 1'b0;
    endtask

    initial begin
        logic [7:0] bits1;
        rst        = 1'b1;
        din4       = 4'h0;
        din1       = 1'b0;
        din_valid  = 1'b0;
        frame_sync = 1'b0;
        model_reset();
        #12;
        compare_all();
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Idle without sync: ignored.
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 4'(i + 1));

        // W=1 pattern 1,0,1,1,0,0,1,0 -> 0x4D.
        bits1 = 8'b0100_1101;
        for (int i = 0; i < 8; i++) cyc(1'b1, (i == 0), {3'b000, bits1[i]});
        check("pattern_w1", {24'h0, y1}, 32'h4D);
        cyc(1'b0, 1'b0, 4'h0);

        // W=4 back-to-back frames with gaps.
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, (i == 0), 4'(i));
            if (i % 3 == 1) cyc(1'b0, 1'b1, 4'hF);
        end
        check("frame1_w4", y4, 32'h76543210);
        for (int i = 0; i < 8; i++) begin
            cyc(1'b1, (i == 0), 4'(i + 8));
            if (i % 2 == 0) cyc(1'b0, 1'b0, 4'h3);
        end
        check("frame2_w4", y4, 32'hFEDCBA98);

        // Early sync at slot 3, then a full post-resync frame.
        cyc(1'b1, 1'b1, 4'h1);
        cyc(1'b1, 1'b0, 4'h2);
        cyc(1'b1, 1'b0, 4'h3);
        cyc(1'b1, 1'b1, 4'h5);
        check("early_sync_err", {31'h0, se4}, 32'h1);
        for (int i = 1; i < 8; i++) cyc(1'b1, 1'b0, 4'(i + 5));
        check("resync_frame", y4, 32'hCBA98765);

        // Missing sync at slot 0, then ignored samples, then relock.
        cyc(1'b1, 1'b0, 4'h9);
        check("missing_sync_lock", {31'h0, lk4}, 32'h0);
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 4'(i));

        // Reset mid-frame at slot 4.
        for (int i = 0; i < 4; i++) cyc(1'b1, (i == 0), 4'(i + 3));
        mid_reset();
        for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 4'h7);

        // Random traffic, mostly well-framed with occasional faults.
        for (int n = 0; n < 600; n++) begin
            bit          v, fs;
            logic [3:0]  d;
            v  = ($urandom_range(0, 3) != 0);
            d  = 4'($urandom);
            if (model_sel() == 0) fs = ($urandom_range(0, 9) != 0);
            else                  fs = ($urandom_range(0, 19) == 0);
            cyc(v, fs, d);
            if ($urandom_range(0, 149) == 0) mid_reset();
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
